// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480 timing, coordinate type and sync decode helper.
// Shared by the raster generator and its per-axis counters.
package vga_timing_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL =
    DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] coord_t;

  function automatic logic sync_active(
    input coord_t      pos,
    input int unsigned start,
    input int unsigned width
  );
    int unsigned p;
    p = 32'(pos);
    return (p >= start) && (p < start + width);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync/visible decode.
// Decode is taken from the next position so it lines up with pos.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT,
  parameter int SYNC_WIDTH = DEF_H_SYNC,
  parameter int DISPLAY    = DEF_H_DISPLAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [9:0] pos,
  output logic       wrap,
  output logic       sync_act,
  output logic       visible
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  coord_t pos_nxt;

  assign wrap    = (pos == LAST);
  assign pos_nxt = wrap ? '0 : pos + coord_t'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos      <= LAST;
      sync_act <= sync_active(LAST, SYNC_START, SYNC_WIDTH);
      visible  <= (32'(LAST) < DISPLAY);
    end else if (adv) begin
      pos      <= pos_nxt;
      sync_act <= sync_active(pos_nxt, SYNC_START, SYNC_WIDTH);
      visible  <= (32'(pos_nxt) < DISPLAY);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing: syncs, display_on, coords, strobes.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  logic h_wrap, h_sync, h_vis;
  logic v_wrap, v_sync, v_vis;
  logic v_adv;

  assign v_adv = pix_en & h_wrap;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC_START(H_DISPLAY + H_FRONT),
    .SYNC_WIDTH(H_SYNC),
    .DISPLAY   (H_DISPLAY)
  ) u_h (
    .clk     (clk),
    .rst     (rst),
    .adv     (pix_en),
    .pos     (hpos),
    .wrap    (h_wrap),
    .sync_act(h_sync),
    .visible (h_vis)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC_START(V_DISPLAY + V_FRONT),
    .SYNC_WIDTH(V_SYNC),
    .DISPLAY   (V_DISPLAY)
  ) u_v (
    .clk     (clk),
    .rst     (rst),
    .adv     (v_adv),
    .pos     (vpos),
    .wrap    (v_wrap),
    .sync_act(v_sync),
    .visible (v_vis)
  );

  assign hsync      = h_sync ^ ~SYNC_POL;
  assign vsync      = v_sync ^ ~SYNC_POL;
  assign display_on = h_vis & v_vis;

  // strobes mark the cycle the counters show the freshly wrapped value
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= v_adv;
      frame_start <= v_adv & v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (v_adv & v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Random pix_en/reset stimulus vs. an arithmetic raster model.
// Default, shrunk and positive-sync instances share one stimulus.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_h, d_v;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_h, s_v;
  logic       p_hs, p_vs, p_de, p_ls, p_fs;
  logic [9:0] p_h, p_v;
  logic [7:0] d_fc, s_fc, p_fc;

`ifndef VGA_FRAME_CNT_EN
  assign d_fc = 8'h0;
  assign s_fc = 8'h0;
  assign p_fc = 8'h0;
`endif

  vga_sync_gen dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .display_on (d_de),
    .hpos       (d_h),
    .vpos       (d_v),
    .line_start (d_ls),
    .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (d_fc)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
    .SYNC_POL (1'b0)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .display_on (s_de),
    .hpos       (s_h),
    .vpos       (s_v),
    .line_start (s_ls),
    .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (s_fc)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
    .SYNC_POL (1'b1)
  ) dut_p (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hsync      (p_hs),
    .vsync      (p_vs),
    .display_on (p_de),
    .hpos       (p_h),
    .vpos       (p_v),
    .line_start (p_ls),
    .frame_start(p_fs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (p_fc)
`endif
  );

  int     total = 0;
  int     bad   = 0;
  longint n     = 0;
  bit     st    = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_inst(
    string nm,
    int ht, int vt, int hd, int hss, int hsw,
    int vd, int vss, int vsw, bit pol,
    logic [9:0] h_o, logic [9:0] v_o,
    logic hs_o, logic vs_o, logic de_o,
    logic ls_o, logic fs_o, logic [7:0] fc_o
  );
    longint f, idx;
    int     h, v;
    bit     hs_e, vs_e;
    f   = longint'(ht) * vt;
    idx = (f - 1 + n) % f;
    h   = int'(idx % ht);
    v   = int'(idx / ht);
    hs_e = (h >= hss && h < hss + hsw) ? pol : !pol;
    vs_e = (v >= vss && v < vss + vsw) ? pol : !pol;
    chk({nm, ".hpos"}, 32'(h_o), 32'(h));
    chk({nm, ".vpos"}, 32'(v_o), 32'(v));
    chk({nm, ".hsync"}, 32'(hs_o), 32'(hs_e));
    chk({nm, ".vsync"}, 32'(vs_o), 32'(vs_e));
    chk({nm, ".display_on"}, 32'(de_o), 32'(h < hd && v < vd));
    chk({nm, ".line_start"}, 32'(ls_o), 32'(st && h == 0));
    chk({nm, ".frame_start"}, 32'(fs_o), 32'(st && idx == 0));
`ifdef VGA_FRAME_CNT_EN
    chk({nm, ".frame_cnt"}, 32'(fc_o), 32'(8'((n + f - 1) / f)));
`else
    if (fc_o !== 8'h0) chk({nm, ".frame_cnt"}, 32'(fc_o), 32'h0);
`endif
  endtask

  task automatic step(bit r, bit pe);
    rst    = r;
    pix_en = pe;
    @(posedge clk);
    if (r) begin
      n  = 0;
      st = 1'b0;
    end else begin
      st = pe;
      if (pe) n++;
    end
    @(negedge clk);
    chk_inst("dflt", 800, 525, 640, 656, 96, 480, 490, 2, 1'b0,
             d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_fc);
    chk_inst("small", 32, 20, 16, 20, 6, 12, 14, 2, 1'b0,
             s_h, s_v, s_hs, s_vs, s_de, s_ls, s_fs, s_fc);
    chk_inst("pos", 32, 20, 16, 20, 6, 12, 14, 2, 1'b1,
             p_h, p_v, p_hs, p_vs, p_de, p_ls, p_fs, p_fc);
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    repeat (3) step(1'b1, 1'b1);
    repeat (2000) step(1'b0, 1'b1);
    repeat (301) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0, (i % 2) == 0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 6000; i++)
      step(($urandom % 1500) == 0, ($urandom % 4) != 0);
    repeat (2) step(1'b1, 1'b0);
    repeat (1500) step(1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
